oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- Bus initiator that performs the OAM DMA transfer on the memory bus.
- Owns register FF46. A CPU write starts a 160-byte copy from `{src,8'h00}` to FE00–FE9F.
- Drives the same addr / data / rd_enable / wr_enable interface that the memory-map decoder responds to.
- Sits beside the CPU; the bus arbiter selects this block's bus outputs while `busy` is high.

Parameters:
- NUM_BYTES, 160, bytes per transfer (OAM size).
- CYCLES_PER_BYTE, 4, clocks per transferred byte; minimum 2.
- START_DELAY, 4, idle clocks between the FF46 write and the first read.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- reg_wr  in  1  CPU write strobe to FF46 (1-cycle pulse).
- reg_wdata  in  8  source high byte.
- reg_rdata  out  8  last value written to FF46.
- bus_addr  out  16  bus address.
- bus_wdata  out  8  bus write data.
- bus_rdata  in  8  bus read data; combinational response, valid in the same cycle as bus_rd.
- bus_rd  out  1  read strobe.
- bus_wr  out  1  write strobe.
- busy  out  1  transfer in progress, including the start delay.
- done  out  1  one-cycle pulse after the last byte is written.

Behaviour:
- Reset values: reg_rdata=0, bus_addr=0, bus_wdata=0, bus_rd=0, bus_wr=0, busy=0, done=0. State=IDLE, idx=0, delay counter=0.
- Reset asserted mid-transfer aborts it immediately; nothing further is written.
- FSM states: IDLE, DELAY, READ, WRITE, PAD.
  - IDLE: on reg_wr, latch src=reg_wdata, set reg_rdata=reg_wdata, go to DELAY, load delay counter with START_DELAY.
  - DELAY: count down. On reaching 0 go to READ with idx=0. If START_DELAY=0, go straight from IDLE to READ.
  - READ (1 clk): bus_rd=1, bus_addr={eff_src, idx}. Latch bus_rdata into the data register at the clock edge.
  - WRITE (1 clk): bus_wr=1, bus_addr=16'hFE00+idx, bus_wdata=latched byte.
  - PAD: CYCLES_PER_BYTE−2 clocks with no strobes. Skipped when CYCLES_PER_BYTE=2.
  - After PAD (or after WRITE if there is no PAD): if idx==NUM_BYTES−1, go to IDLE and pulse done; else idx+1 and go to READ.
- busy=1 in every state except IDLE. It drops in the same cycle done pulses.
- bus_rd and bus_wr are never both high. Both are 0 outside READ and WRITE, and bus_addr holds its last value there.
- eff_src handling:
  - If src ≥ 8'hE0, eff_src = src − 8'h20 (echo-RAM mirror to C000–DFFF).
  - Otherwise eff_src = src.
  - reg_rdata always returns the raw src.
- idx is 8 bits and never exceeds NUM_BYTES−1.
- Restart: reg_wr in any non-IDLE state re-latches src, abandons the current byte (no write for it), reloads the delay and re-enters DELAY.
  - If reg_wr coincides with the final WRITE, that write still completes, done is suppressed, and the restart proceeds.
- Total duration = START_DELAY + NUM_BYTES·CYCLES_PER_BYTE clocks from the cycle after reg_wr to done.

Optional Feature:
- Macro OAM_DMA_CPU_LOCKOUT_EN.
- Defined:
  - Extra ports: cpu_addr in 16, cpu_blocked out 1.
  - cpu_blocked = busy && !(cpu_addr in FF80..FFFE), combinational.
  - The CPU wrapper uses cpu_blocked to return 8'hFF and drop writes.
- Not defined: these ports are absent, and the CPU is responsible for HRAM-only execution during DMA.

Decomposition:
- Shared package gb_bus_pkg holds:
  - dma_state_t enum (IDLE, DELAY, READ, WRITE, PAD).
  - Constants OAM_BASE=16'hFE00, HRAM_BASE=16'hFF80, HRAM_LAST=16'hFFFE, REG_DMA=16'hFF46, ECHO_BASE_HI=8'hE0.
- No sub-module; a single FSM plus counters. The lockout comparator stays inline.

Test Plan:
- Basic copy, src=8'hC1, memory model C100+i=i^8'h5A → exactly 160 writes, FE00+i=i^8'h5A; done after 4+640 clocks; busy high throughout.
- Strobe timing → every bus_rd cycle at C100+i is followed one clock later by bus_wr at FE00+i, then 2 idle clocks; bus_rd and bus_wr never overlap.
- Echo source, src=8'hE2 → reads at C200–C29F; reg_rdata=8'hE2.
- Restart, reg_wr src=8'hC0, then reg_wr src=8'hD0 at idx=50 → write for byte 50 is not issued, a fresh 4-clock delay follows, and 160 writes come from D000–D09F with one done pulse.
- Reset at idx=80 → next clock bus_rd=bus_wr=busy=0; no further writes; a later reg_wr runs a full 160-byte transfer.
- With OAM_DMA_CPU_LOCKOUT_EN during busy → cpu_addr=FF90 gives cpu_blocked=0; cpu_addr=C000 and FFFF give cpu_blocked=1; all give 0 when idle.

Source files
------------

// File: rtl/gb_bus_pkg.sv
// Shared bus definitions for the Game Boy memory-map blocks: DMA state encoding,
// fixed map addresses and the echo-RAM source fold used by OAM DMA.
package gb_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        READ,
        WRITE,
        PAD
    } dma_state_t;

    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] HRAM_BASE    = 16'hFF80;
    localparam logic [15:0] HRAM_LAST    = 16'hFFFE;
    localparam logic [15:0] REG_DMA      = 16'hFF46;
    localparam logic [7:0]  ECHO_BASE_HI = 8'hE0;

    // E000-FFFF sources are mirrored down onto work RAM at C000-DFFF.
    function automatic logic [7:0] echo_fold(input logic [7:0] src);
        return (src >= ECHO_BASE_HI) ? (src - 8'h20) : src;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA bus initiator: a write to FF46 copies NUM_BYTES bytes from {src,8'h00}
// into OAM. Optional CPU lockout output is enabled by macro OAM_DMA_CPU_LOCKOUT_EN.
module oam_dma
    import gb_bus_pkg::*;
#(
    parameter int NUM_BYTES       = 160,
    parameter int CYCLES_PER_BYTE = 4,
    parameter int START_DELAY     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reg_wr,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic        busy,
`ifdef OAM_DMA_CPU_LOCKOUT_EN
    input  logic [15:0] cpu_addr,
    output logic        cpu_blocked,
`endif
    output logic        done
);

    localparam logic [7:0] DELAY_LOAD = 8'(START_DELAY);
    localparam logic [7:0] PAD_LOAD   = 8'(CYCLES_PER_BYTE - 2);
    localparam logic [7:0] LAST_IDX   = 8'(NUM_BYTES - 1);

    dma_state_t  r_state;
    dma_state_t  w_state_next;
    logic [7:0]  r_idx;
    logic [7:0]  w_idx_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic [7:0]  r_src;
    logic [7:0]  r_data;
    logic [15:0] r_addr_hold;
    logic        r_done;
    logic        w_done_next;
    logic [15:0] w_bus_addr;
    logic        w_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_idx       <= 8'd0;
            r_cnt       <= 8'd0;
            r_src       <= 8'd0;
            r_data      <= 8'd0;
            r_addr_hold <= 16'd0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_cnt       <= w_cnt_next;
            r_done      <= w_done_next;
            r_addr_hold <= w_bus_addr;
            if (reg_wr) begin
                r_src <= reg_wdata;
            end
            if (r_state == READ) begin
                r_data <= bus_rdata;
            end
        end
    end

    assign w_last = (r_idx == LAST_IDX);

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        // A register write wins over everything, including an in-flight byte.
        if (reg_wr) begin
            w_idx_next = 8'd0;
            if (START_DELAY == 0) begin
                w_state_next = READ;
                w_cnt_next   = 8'd0;
            end else begin
                w_state_next = DELAY;
                w_cnt_next   = DELAY_LOAD;
            end
        end else begin
            case (r_state)
                DELAY: begin
                    if (r_cnt <= 8'd1) begin
                        w_state_next = READ;
                        w_cnt_next   = 8'd0;
                    end else begin
                        w_cnt_next = r_cnt - 8'd1;
                    end
                end
                READ: begin
                    w_state_next = WRITE;
                end
                WRITE, PAD: begin
                    if ((r_state == WRITE) && (CYCLES_PER_BYTE > 2)) begin
                        w_state_next = PAD;
                        w_cnt_next   = PAD_LOAD;
                    end else if ((r_state == PAD) && (r_cnt > 8'd1)) begin
                        w_cnt_next = r_cnt - 8'd1;
                    end else if (w_last) begin
                        w_state_next = IDLE;
                        w_cnt_next   = 8'd0;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = READ;
                        w_cnt_next   = 8'd0;
                        w_idx_next   = r_idx + 8'd1;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus_rd     = 1'b0;
        bus_wr     = 1'b0;
        w_bus_addr = r_addr_hold;
        case (r_state)
            READ: begin
                bus_rd     = 1'b1;
                w_bus_addr = {echo_fold(r_src), r_idx};
            end
            WRITE: begin
                bus_wr     = 1'b1;
                w_bus_addr = OAM_BASE + {8'h00, r_idx};
            end
            default: begin
                bus_rd = 1'b0;
            end
        endcase
    end

    assign bus_addr  = w_bus_addr;
    assign bus_wdata = r_data;
    assign reg_rdata = r_src;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

`ifdef OAM_DMA_CPU_LOCKOUT_EN
    assign cpu_blocked = busy && !((cpu_addr >= HRAM_BASE) && (cpu_addr <= HRAM_LAST));
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma with a schedule-based reference model; also exercises
// the OAM_DMA_CPU_LOCKOUT_EN ports when that macro is defined.
module tb_oam_dma;

    localparam int SD  = 4;
    localparam int CPB = 4;
    localparam int NB  = 160;
    localparam int END_OFS = SD + NB * CPB + 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        reg_wr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_rd;
    logic        bus_wr;
    logic        busy;
    logic        done;
`ifdef OAM_DMA_CPU_LOCKOUT_EN
    logic [15:0] cpu_addr;
    logic        cpu_blocked;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    oam_dma #(.NUM_BYTES(NB), .CYCLES_PER_BYTE(CPB), .START_DELAY(SD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .reg_wr     (reg_wr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_rd     (bus_rd),
        .bus_wr     (bus_wr),
        .busy       (busy),
`ifdef OAM_DMA_CPU_LOCKOUT_EN
        .cpu_addr   (cpu_addr),
        .cpu_blocked(cpu_blocked),
`endif
        .done       (done)
    );

    // Page C1 reads back i^5A; other pages are distinguished by the high byte.
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'hC1;
    endfunction

    function automatic logic [7:0] eff_m(input logic [7:0] s);
        return (s >= 8'hE0) ? (s - 8'h20) : s;
    endfunction

    always_comb bus_rdata = mem_f(bus_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: position within a transfer as a plain cycle offset.
    bit          m_active = 1'b0;
    int          m_ofs    = 0;
    logic [7:0]  m_src    = 8'h00;
    logic [15:0] m_last   = 16'h0000;

    // Statistics observed from the DUT, read by the stimulus for literal checks.
    int          cyc = 0;
    int          wr_count = 0;
    int          done_count = 0;
    int          start_cyc = 0;
    int          lat = 0;
    bit          first_wr_seen = 1'b0;
    bit          first_rd_seen = 1'b0;
    logic [7:0]  first_wr_data = 8'h00;
    logic [15:0] first_rd_addr = 16'h0000;
    logic [15:0] last_rd_addr  = 16'h0000;
    logic [15:0] last_wr_addr  = 16'h0000;
    logic [7:0]  last_wr_data  = 8'h00;

    initial begin
        forever begin
            bit          e_busy, e_done, e_rd, e_wr;
            logic [15:0] e_addr;
            logic [7:0]  e_wdata;
            int          k, b, ph;
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                m_active = 1'b0;
                m_ofs    = 0;
                m_src    = 8'h00;
                m_last   = 16'h0000;
            end
            e_busy = 1'b0; e_done = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
            e_addr = m_last; e_wdata = 8'h00;
            if (m_active) begin
                if (m_ofs <= SD) begin
                    e_busy = 1'b1;
                end else begin
                    k  = m_ofs - SD - 1;
                    b  = k / CPB;
                    ph = k % CPB;
                    if (b < NB) begin
                        e_busy = 1'b1;
                        if (ph == 0) begin
                            e_rd   = 1'b1;
                            e_addr = {eff_m(m_src), 8'(b)};
                        end else if (ph == 1) begin
                            e_wr    = 1'b1;
                            e_addr  = 16'hFE00 + 16'(b);
                            e_wdata = mem_f({eff_m(m_src), 8'(b)});
                        end
                    end else begin
                        e_done = 1'b1;
                    end
                end
            end
            chk("busy", {31'd0, busy}, {31'd0, e_busy});
            chk("done", {31'd0, done}, {31'd0, e_done});
            chk("bus_rd", {31'd0, bus_rd}, {31'd0, e_rd});
            chk("bus_wr", {31'd0, bus_wr}, {31'd0, e_wr});
            chk("rd_wr_overlap", {31'd0, bus_rd & bus_wr}, 32'd0);
            chk("bus_addr", {16'd0, bus_addr}, {16'd0, e_addr});
            chk("reg_rdata", {24'd0, reg_rdata}, {24'd0, m_src});
            if (e_wr) chk("bus_wdata", {24'd0, bus_wdata}, {24'd0, e_wdata});
`ifdef OAM_DMA_CPU_LOCKOUT_EN
            chk("cpu_blocked", {31'd0, cpu_blocked},
                {31'd0, e_busy && !((cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE))});
`endif
            if (bus_wr) begin
                wr_count++;
                last_wr_addr = bus_addr;
                last_wr_data = bus_wdata;
                if (!first_wr_seen) begin
                    first_wr_seen = 1'b1;
                    first_wr_data = bus_wdata;
                end
            end
            if (bus_rd) begin
                last_rd_addr = bus_addr;
                if (!first_rd_seen) begin
                    first_rd_seen = 1'b1;
                    first_rd_addr = bus_addr;
                end
            end
            if (done) begin
                done_count++;
                lat = cyc - start_cyc;
            end
            // Advance the model using the inputs the next rising edge will sample.
            m_last = e_addr;
            if (!reset_n) begin
                m_active = 1'b0;
                m_last   = 16'h0000;
            end else if (reg_wr) begin
                m_active = 1'b1;
                m_ofs    = 1;
                m_src    = reg_wdata;
                start_cyc = cyc;
                first_wr_seen = 1'b0;
                first_rd_seen = 1'b0;
            end else if (m_active) begin
                if (m_ofs == END_OFS) m_active = 1'b0;
                else m_ofs++;
            end
        end
    end

`ifdef OAM_DMA_CPU_LOCKOUT_EN
    initial begin
        logic [15:0] tbl [4];
        tbl[0] = 16'hFF90; tbl[1] = 16'hC000; tbl[2] = 16'hFFFF; tbl[3] = 16'hFF80;
        cpu_addr = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            cpu_addr = tbl[$urandom_range(0, 3)];
        end
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic start(input logic [7:0] s);
        reg_wr    = 1'b1;
        reg_wdata = s;
        tick();
        reg_wr    = 1'b0;
        reg_wdata = 8'h00;
    endtask

    initial begin
        int w0, d0;
        reset_n   = 1'b0;
        reg_wr    = 1'b0;
        reg_wdata = 8'h00;
        run(3);
        reset_n = 1'b1;
        run(2);

        // Basic copy from C100.
        w0 = wr_count; d0 = done_count;
        start(8'hC1);
        run(700);
        chk("basic_writes", 32'(wr_count - w0), 32'd160);
        chk("basic_done", 32'(done_count - d0), 32'd1);
        chk("basic_latency", 32'(lat), 32'd645);   // reg_wr cycle + 4 delay + 640 byte clocks
        chk("basic_first_wdata", {24'd0, first_wr_data}, 32'h5A);
        chk("basic_last_waddr", {16'd0, last_wr_addr}, 32'hFE9F);
        chk("basic_last_wdata", {24'd0, last_wr_data}, 32'hC5);
        chk("basic_first_raddr", {16'd0, first_rd_addr}, 32'hC100);

        // Echo-RAM source.
        start(8'hE2);
        run(700);
        chk("echo_first_raddr", {16'd0, first_rd_addr}, 32'hC200);
        chk("echo_last_raddr", {16'd0, last_rd_addr}, 32'hC29F);
        chk("echo_reg_rdata", {24'd0, reg_rdata}, 32'hE2);

        // Restart during the read of byte 50.
        w0 = wr_count; d0 = done_count;
        start(8'hC0);
        run(SD + 50 * CPB);
        start(8'hD0);
        run(700);
        chk("restart_writes", 32'(wr_count - w0), 32'd210);
        chk("restart_done", 32'(done_count - d0), 32'd1);
        chk("restart_first_raddr", {16'd0, first_rd_addr}, 32'hD000);
        chk("restart_latency", 32'(lat), 32'd645);

        // Restart coinciding with the final write: that write lands, no done for it.
        w0 = wr_count; d0 = done_count;
        start(8'hC5);
        run(SD + 159 * CPB + 1);
        start(8'hC6);
        run(700);
        chk("final_restart_writes", 32'(wr_count - w0), 32'd320);
        chk("final_restart_done", 32'(done_count - d0), 32'd1);

        // Reset during the read of byte 80.
        w0 = wr_count; d0 = done_count;
        start(8'hC3);
        run(SD + 80 * CPB);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        run(50);
        chk("reset_writes", 32'(wr_count - w0), 32'd80);
        chk("reset_done", 32'(done_count - d0), 32'd0);
        chk("reset_reg_rdata", {24'd0, reg_rdata}, 32'h00);
        w0 = wr_count; d0 = done_count;
        start(8'(8'h80 + $urandom_range(0, 127)));
        run(700);
        chk("post_reset_writes", 32'(wr_count - w0), 32'd160);
        chk("post_reset_done", 32'(done_count - d0), 32'd1);

        // Random sources with random restart points.
        for (int i = 0; i < 5; i++) begin
            start(8'($urandom));
            run($urandom_range(20, 700));
        end
        run(700);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
